tetris_collision_check: RTL and testbench
=========================================

Name: tetris_collision_check

Overview:
- Sequential consumer of tetris_piece_offsets.
- Takes a candidate placement (anchor x/y, shape_id, rot), drives shape/rot to the offsets block, and walks the 4 returned cells.
- Each cell is checked against playfield bounds and the board occupancy RAM (1-cycle read latency).
- Returns a single blocked/clear verdict to the piece controller, used for move, rotate, drop and spawn legality.

Parameters:
BOARD_W, 10, playfield width in cells (max 16)
BOARD_H, 20, playfield height in cells (max 32)
ADDR_W, 8, board RAM address width; address = y*BOARD_W + x

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  candidate placement present
req_ready  out  1  block can accept a request (high only in IDLE)
req_x  in  4  anchor column (unsigned)
req_y  in  5  anchor row (unsigned, 0 = top)
req_shape  in  3  shape_id (0..6 = O,I,J,L,S,T,Z)
req_rot  in  2  rotation 0..3
off_shape  out  3  registered shape_id to offsets block
off_rot  out  2  registered rot to offsets block
dx0..dx3, dy0..dy3  in  2 each  cell offsets from offsets block (combinational from off_shape/off_rot)
rd_en  out  1  board RAM read strobe
rd_addr  out  ADDR_W  board RAM read address
rd_data  in  1  occupancy of address read on the previous cycle (1 = filled)
resp_valid  out  1  verdict available
resp_ready  in  1  consumer takes verdict
resp_blocked  out  1  1 = placement illegal
resp_oob  out  1  1 = illegal because a cell is outside the playfield (valid only with resp_blocked)

Behaviour:
- Reset: asynchronous, active-high; applies immediately, at any state.
  - state=IDLE, idx=0.
  - req_ready=1.
  - rd_en=0, rd_addr=0.
  - resp_valid=0, resp_blocked=0, resp_oob=0.
  - off_shape=0, off_rot=0.
  - Any in-flight check is discarded; no response is produced for it.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch x, y, shape and rot (off_shape/off_rot update at this edge); go to ISSUE with idx=0.
- ISSUE (idx 0..3):
  - Select dx/dy by idx.
  - cell_x = {1'b0,x} + dx (5 bits); cell_y = {1'b0,y} + dy (6 bits); no wrap.
  - OOB when cell_x >= BOARD_W or cell_y >= BOARD_H.
  - Not OOB: rd_en=1, rd_addr = cell_y*BOARD_W + cell_x.
  - OOB: rd_en=0; set blocked=1 and oob=1; go to DONE.
  - For idx >= 1, rd_data reflects cell idx-1 in the same cycle. If rd_data=1: blocked=1, oob=0, go to DONE; the current issue is discarded.
  - An occupied result for cell idx-1 takes priority over OOB of cell idx (oob=0).
  - Otherwise idx=3 goes to DRAIN; idx<3 increments idx.
- DRAIN:
  - rd_en=0.
  - rd_data reflects cell 3; blocked=rd_data, oob=0; go to DONE.
- DONE:
  - resp_valid=1; resp_blocked/resp_oob held stable.
  - Leave to IDLE when resp_ready=1; resp_valid drops the next cycle.
  - req_ready=0 in DONE, so no new request overlaps a pending verdict.
- Latency (accept edge = cycle A):
  - Clear placement: ISSUE A+1..A+4, DRAIN A+5, resp_valid at A+6.
  - Early exits shorten this: OOB at idx k gives resp_valid at A+k+2; occupied cell k gives resp_valid at A+k+3.
- rd_en is never asserted outside ISSUE; at most 4 reads per request.
- req_x/y/shape/rot may change after the accept edge without effect.
- Offsets of non-zero shape_id>6 are all zero from upstream; treated normally (single cell repeated 4 times).

Test Plan:
- Empty board, O (shape 0, rot 0) at x=0,y=0 -> reads at addr 11,12,21,22 on A+1..A+4; resp_valid at A+6, blocked=0.
- Same request, RAM addr 22 preloaded =1 -> read 22 at A+4, DRAIN sees 1; resp_valid A+6, blocked=1, oob=0.
- I rot1 at x=7,y=5 -> reads 57,58,59; cell 3 x=10 OOB at A+4, no read; resp_valid A+5, blocked=1, oob=1.
- I rot0 at x=3,y=17 -> cell 3 y=20 OOB; resp_valid A+5, blocked=1, oob=1. J rot0 at x=0,y=0, addr 0 filled -> detected at A+2; resp_valid A+3, blocked=1, oob=0.
- Hold resp_ready=0 for 5 cycles -> resp_valid/blocked stable, req_ready=0, req_valid ignored. Assert reset during ISSUE idx=2 -> immediate IDLE, rd_en=0, no resp_valid. Next request completes normally.

Source files
------------

// File: rtl/tetris_collision_check.sv
// Checks whether a candidate tetromino placement is legal: walks the 4 cells from the
// offsets block, bounds-checks each one and looks it up in the 1-cycle-latency board RAM.
module tetris_collision_check #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_x,
    input  logic [4:0]        req_y,
    input  logic [2:0]        req_shape,
    input  logic [1:0]        req_rot,
    output logic [2:0]        off_shape,
    output logic [1:0]        off_rot,
    input  logic [1:0]        dx0,
    input  logic [1:0]        dx1,
    input  logic [1:0]        dx2,
    input  logic [1:0]        dx3,
    input  logic [1:0]        dy0,
    input  logic [1:0]        dy1,
    input  logic [1:0]        dy2,
    input  logic [1:0]        dy3,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_blocked,
    output logic              resp_oob
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [4:0]        BW_X = 5'(BOARD_W);
    localparam logic [5:0]        BH_Y = 6'(BOARD_H);
    localparam logic [ADDR_W-1:0] BW_A = ADDR_W'(BOARD_W);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [2:0]  shape_q, shape_d;
    logic [1:0]  rot_q, rot_d;
    logic        blocked_q, blocked_d;
    logic        oob_q, oob_d;

    logic [1:0]        dx_sel, dy_sel;
    logic [4:0]        cell_x;
    logic [5:0]        cell_y;
    logic              cell_oob;
    logic              hit;
    logic [ADDR_W-1:0] cell_addr;

    always_comb begin
        case (idx_q)
            2'd0:    begin dx_sel = dx0; dy_sel = dy0; end
            2'd1:    begin dx_sel = dx1; dy_sel = dy1; end
            2'd2:    begin dx_sel = dx2; dy_sel = dy2; end
            default: begin dx_sel = dx3; dy_sel = dy3; end
        endcase
    end

    // Widened sums so an anchor near the edge reports OOB instead of wrapping back in.
    assign cell_x    = {1'b0, x_q} + {3'b000, dx_sel};
    assign cell_y    = {1'b0, y_q} + {4'b0000, dy_sel};
    assign cell_oob  = (cell_x >= BW_X) || (cell_y >= BH_Y);
    assign cell_addr = ADDR_W'(cell_y) * BW_A + ADDR_W'(cell_x);
    // rd_data in ISSUE idx>=1 is the occupancy of the previous cell.
    assign hit       = (idx_q != 2'd0) && rd_data;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        shape_d    = shape_q;
        rot_d      = rot_q;
        blocked_d  = blocked_q;
        oob_d      = oob_q;
        req_ready  = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    x_d       = req_x;
                    y_d       = req_y;
                    shape_d   = req_shape;
                    rot_d     = req_rot;
                    idx_d     = 2'd0;
                    blocked_d = 1'b0;
                    oob_d     = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (hit) begin
                    blocked_d = 1'b1;
                    oob_d     = 1'b0;
                    state_d   = DONE;
                end else if (cell_oob) begin
                    blocked_d = 1'b1;
                    oob_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = cell_addr;
                    if (idx_q == 2'd3) state_d = DRAIN;
                    else               idx_d   = idx_q + 2'd1;
                end
            end
            DRAIN: begin
                blocked_d = rd_data;
                oob_d     = 1'b0;
                state_d   = DONE;
            end
            default: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            x_q       <= 4'd0;
            y_q       <= 5'd0;
            shape_q   <= 3'd0;
            rot_q     <= 2'd0;
            blocked_q <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            shape_q   <= shape_d;
            rot_q     <= rot_d;
            blocked_q <= blocked_d;
            oob_q     <= oob_d;
        end
    end

    assign off_shape    = shape_q;
    assign off_rot      = rot_q;
    assign resp_blocked = blocked_q;
    assign resp_oob     = oob_q;

endmodule

// File: tb/tb_tetris_collision_check.sv
// Directed bench: offsets-block and board-RAM models, fixed placements with hand-derived
// read addresses, verdicts and cycle positions.
module tb_tetris_collision_check;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_x = '0;
    logic [4:0] req_y = '0;
    logic [2:0] req_shape = '0;
    logic [1:0] req_rot = '0;
    logic [2:0] off_shape;
    logic [1:0] off_rot;
    logic [1:0] dx0, dx1, dx2, dx3, dy0, dy1, dy2, dy3;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       rd_data = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic       resp_blocked;
    logic       resp_oob;

    logic       mem [256];
    int         vectors = 0;
    int         miscompares = 0;

    tetris_collision_check #(.BOARD_W(10), .BOARD_H(20), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_shape(req_shape), .req_rot(req_rot),
        .off_shape(off_shape), .off_rot(off_rot),
        .dx0(dx0), .dx1(dx1), .dx2(dx2), .dx3(dx3),
        .dy0(dy0), .dy1(dy1), .dy2(dy2), .dy3(dy3),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_blocked(resp_blocked), .resp_oob(resp_oob)
    );

    always #5 clk = ~clk;

    // Board RAM: 1-cycle read latency, output holds when not read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Offsets for the shapes exercised: O, I rot0/rot1, J rot0; everything else zero.
    always_comb begin
        {dx0, dx1, dx2, dx3} = '0;
        {dy0, dy1, dy2, dy3} = '0;
        case (off_shape)
            3'd0: begin
                dx0 = 2'd1; dx1 = 2'd2; dx2 = 2'd1; dx3 = 2'd2;
                dy0 = 2'd1; dy1 = 2'd1; dy2 = 2'd2; dy3 = 2'd2;
            end
            3'd1: begin
                if (off_rot[0]) begin
                    dx0 = 2'd0; dx1 = 2'd1; dx2 = 2'd2; dx3 = 2'd3;
                end else begin
                    dx0 = 2'd1; dx1 = 2'd1; dx2 = 2'd1; dx3 = 2'd1;
                    dy0 = 2'd0; dy1 = 2'd1; dy2 = 2'd2; dy3 = 2'd3;
                end
            end
            3'd2: begin
                if (off_rot == 2'd0) begin
                    dx0 = 2'd0; dx1 = 2'd0; dx2 = 2'd1; dx3 = 2'd2;
                    dy0 = 2'd0; dy1 = 2'd1; dy2 = 2'd1; dy3 = 2'd1;
                end
            end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic en, input logic [7:0] addr);
        chk({tag, "_en"}, 32'(rd_en), 32'(en));
        if (en) chk({tag, "_addr"}, 32'(rd_addr), 32'(addr));
    endtask

    // Presents a request in IDLE; returns in cycle A+1 with garbage on the request bus.
    task automatic send(input logic [3:0] x, input logic [4:0] y,
                        input logic [2:0] s, input logic [1:0] r);
        req_valid = 1'b1; req_x = x; req_y = y; req_shape = s; req_rot = r;
        step();
        req_valid = 1'b0; req_x = 4'hF; req_y = 5'h1F; req_shape = 3'd5; req_rot = 2'd3;
    endtask

    // Checks the verdict cycle, then the return to IDLE (resp_ready assumed high).
    task automatic verdict(input string tag, input logic blk, input logic oob);
        chk({tag, "_rv"}, 32'(resp_valid), 32'd1);
        chk({tag, "_blk"}, 32'(resp_blocked), 32'(blk));
        if (blk) chk({tag, "_oob"}, 32'(resp_oob), 32'(oob));
        chk({tag, "_rdy_done"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, "_rv_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, "_rdy_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic saw_resp;
        for (int i = 0; i < 256; i++) mem[i] = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rv", 32'(resp_valid), 32'd0);
        chk("rst_blk", 32'(resp_blocked), 32'd0);
        chk("rst_oob", 32'(resp_oob), 32'd0);
        chk("rst_off", 32'({off_shape, off_rot}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step();

        // O at (0,0), empty board: clear after full walk
        send(4'd0, 5'd0, 3'd0, 2'd0);
        chk_rd("o_c0", 1'b1, 8'd11); step();
        chk_rd("o_c1", 1'b1, 8'd12); step();
        chk_rd("o_c2", 1'b1, 8'd21); step();
        chk_rd("o_c3", 1'b1, 8'd22); step();
        chk("o_drain_en", 32'(rd_en), 32'd0);
        chk("o_drain_rv", 32'(resp_valid), 32'd0);
        step();
        verdict("o_clear", 1'b0, 1'b0);

        // Same placement, addr 22 filled: caught in DRAIN
        mem[22] = 1'b1;
        send(4'd0, 5'd0, 3'd0, 2'd0);
        step(); step(); step();
        chk_rd("o22_c3", 1'b1, 8'd22); step();
        chk("o22_drain_rv", 32'(resp_valid), 32'd0);
        step();
        verdict("o22_blk", 1'b1, 1'b0);
        mem[22] = 1'b0;

        // I rot1 at (7,5): cell 3 x=10 out of bounds
        send(4'd7, 5'd5, 3'd1, 2'd1);
        chk("i1_off", 32'({off_shape, off_rot}), 32'({3'd1, 2'd1}));
        chk_rd("i1_c0", 1'b1, 8'd57); step();
        chk_rd("i1_c1", 1'b1, 8'd58); step();
        chk_rd("i1_c2", 1'b1, 8'd59); step();
        chk_rd("i1_c3", 1'b0, 8'd0);
        chk("i1_rv_early", 32'(resp_valid), 32'd0);
        step();
        verdict("i1_oobx", 1'b1, 1'b1);

        // I rot0 at (3,17): cells (4,17..20), cell 3 y=20 out of bounds
        send(4'd3, 5'd17, 3'd1, 2'd0);
        chk_rd("i0_c0", 1'b1, 8'd174); step();
        chk_rd("i0_c1", 1'b1, 8'd184); step();
        chk_rd("i0_c2", 1'b1, 8'd194); step();
        chk_rd("i0_c3", 1'b0, 8'd0); step();
        verdict("i0_ooby", 1'b1, 1'b1);

        // O at (7,17): bottom-right corner cells 188,189,198,199, all in bounds
        send(4'd7, 5'd17, 3'd0, 2'd0);
        chk_rd("oc_c0", 1'b1, 8'd188); step();
        chk_rd("oc_c1", 1'b1, 8'd189); step();
        chk_rd("oc_c2", 1'b1, 8'd198); step();
        chk_rd("oc_c3", 1'b1, 8'd199); step();
        step();
        verdict("oc_clear", 1'b0, 1'b0);

        // J rot0 at (0,0), addr 0 filled: occupied cell 0 seen at A+2
        mem[0] = 1'b1;
        send(4'd0, 5'd0, 3'd2, 2'd0);
        chk_rd("j_c0", 1'b1, 8'd0); step();
        chk("j_rv_a2", 32'(resp_valid), 32'd0);
        step();
        verdict("j_occ", 1'b1, 1'b0);
        mem[0] = 1'b0;

        // Verdict held under backpressure, new requests ignored
        mem[21] = 1'b1;
        resp_ready = 1'b0;
        send(4'd0, 5'd0, 3'd0, 2'd0);
        for (int i = 0; i < 5; i++) step();
        req_valid = 1'b1; req_x = 4'd7; req_y = 5'd5; req_shape = 3'd1; req_rot = 2'd1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rv", 32'(resp_valid), 32'd1);
            chk("hold_blk", 32'({resp_blocked, resp_oob}), 32'b10);
            chk("hold_rdy", 32'(req_ready), 32'd0);
            step();
        end
        chk("hold_off", 32'({off_shape, off_rot}), 32'd0);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        chk("hold_rel_rv", 32'(resp_valid), 32'd0);
        chk("hold_rel_rdy", 32'(req_ready), 32'd1);
        mem[21] = 1'b0;

        // Asynchronous reset mid-walk (ISSUE idx 2): aborted, no verdict ever appears
        send(4'd0, 5'd0, 3'd1, 2'd1);
        step(); step();
        chk_rd("rst_mid_pre", 1'b1, 8'd2);
        reset = 1'b1;
        #1;
        chk("rstm_rdy", 32'(req_ready), 32'd1);
        chk("rstm_rd_en", 32'(rd_en), 32'd0);
        chk("rstm_rd_addr", 32'(rd_addr), 32'd0);
        chk("rstm_off", 32'({off_shape, off_rot}), 32'd0);
        chk("rstm_rv", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp_valid || rd_en) saw_resp = 1'b1;
        end
        chk("rstm_quiet", 32'(saw_resp), 32'd0);

        // Normal request after the aborted one
        send(4'd0, 5'd0, 3'd0, 2'd0);
        chk_rd("post_c0", 1'b1, 8'd11); step();
        chk_rd("post_c1", 1'b1, 8'd12); step();
        chk_rd("post_c2", 1'b1, 8'd21); step();
        chk_rd("post_c3", 1'b1, 8'd22); step();
        step();
        verdict("post_clear", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
